// File: rtl/bc_broadcast_source.sv
// ============================================================================
// bc_broadcast_source
// Head-of-chain broadcast transmitter: buffers a vector from a producer and
// streams it (optionally replayed several times) into lane 0.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bc_broadcast_source #(
    parameter int DEPTH    = 8,
    parameter int CntWidth = 16,
    parameter int ELEN     = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [CntWidth-1:0] req_len_i,
    input  logic [7:0]          req_passes_i,
    input  logic                src_valid_i,
    input  logic [ELEN-1:0]     src_data_i,
    output logic                src_ready_o,
    output logic                bc_valid_o,
    output logic [ELEN-1:0]     bc_data_o,
    input  logic                bc_ready_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]       FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [CntWidth-1:0] DEPTH_LEN = CntWidth'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_REPLAY = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [ELEN-1:0]     buf_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [AW:0]         cnt_q, cnt_d;
    logic [CntWidth-1:0] in_cnt_q, in_cnt_d;
    logic [CntWidth-1:0] out_cnt_q, out_cnt_d;
    logic [CntWidth-1:0] len_q, len_d;
    logic [7:0]          pass_left_q, pass_left_d;
    logic                err_q, err_d;

    logic                w_src_rdy, w_bc_vld, w_src_fire, w_bc_fire, w_last;
    logic [7:0]          w_passes;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        len_d       = len_q;
        pass_left_d = pass_left_q;
        err_d       = 1'b0;
        req_ready_o = 1'b0;
        w_src_rdy   = 1'b0;
        w_bc_vld    = 1'b0;
        w_passes    = (req_passes_i == 8'd0) ? 8'd1 : req_passes_i;

        case (state_q)
            S_STREAM: begin
                w_src_rdy = (cnt_q < FULL_CNT) && (in_cnt_q < len_q);
                w_bc_vld  = (cnt_q != '0);
            end
            S_REPLAY: w_bc_vld = 1'b1;
            default: ;
        endcase

        w_src_fire = src_valid_i && w_src_rdy;
        w_bc_fire  = w_bc_vld && bc_ready_i;
        w_last     = (out_cnt_q == (len_q - CntWidth'(1)));

        case (state_q)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    if (req_len_i == '0) begin
                        state_d = S_DONE;
                    end else if ((w_passes > 8'd1) && (req_len_i > DEPTH_LEN)) begin
                        // Replay needs the whole vector resident in the buffer
                        err_d = 1'b1;
                    end else begin
                        state_d     = S_STREAM;
                        wr_ptr_d    = '0;
                        rd_ptr_d    = '0;
                        cnt_d       = '0;
                        in_cnt_d    = '0;
                        out_cnt_d   = '0;
                        len_d       = req_len_i;
                        pass_left_d = w_passes;
                    end
                end
            end
            S_STREAM, S_REPLAY: begin
                if (w_src_fire) begin
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    in_cnt_d = in_cnt_q + CntWidth'(1);
                end
                if (state_q == S_STREAM) begin
                    if (w_src_fire && !w_bc_fire)      cnt_d = cnt_q + (AW+1)'(1);
                    else if (!w_src_fire && w_bc_fire) cnt_d = cnt_q - (AW+1)'(1);
                end
                if (w_bc_fire) begin
                    rd_ptr_d  = rd_ptr_q + AW'(1);
                    out_cnt_d = out_cnt_q + CntWidth'(1);
                    if (w_last) begin
                        if (pass_left_q == 8'd1) begin
                            state_d = S_DONE;
                        end else begin
                            state_d     = S_REPLAY;
                            rd_ptr_d    = '0;
                            out_cnt_d   = '0;
                            pass_left_d = pass_left_q - 8'd1;
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            len_q       <= '0;
            pass_left_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            len_q       <= len_d;
            pass_left_q <= pass_left_d;
            err_q       <= err_d;
        end
    end

    // Payload storage needs no reset; validity is tracked by cnt/state
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_src_fire) begin
            buf_q[wr_ptr_q] <= src_data_i;
        end
    end

    assign src_ready_o = w_src_rdy;
    assign bc_valid_o  = w_bc_vld;
    assign bc_data_o   = buf_q[rd_ptr_q];
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);
    assign err_o       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_bc_broadcast_source.sv
// ============================================================================
// tb_bc_broadcast_source
// Directed + randomized bench for bc_broadcast_source against a vector model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bc_broadcast_source;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [15:0] req_len_i = '0;
    logic [7:0]  req_passes_i = '0;
    logic        src_valid_i = 1'b0;
    logic [63:0] src_data_i = '0;
    logic        src_ready_o;
    logic        bc_valid_o;
    logic [63:0] bc_data_o;
    logic        bc_ready_i = 1'b0;
    logic        busy_o, done_o, err_o;

    bc_broadcast_source #(.DEPTH(DEPTH), .CntWidth(16), .ELEN(64)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_len_i(req_len_i), .req_passes_i(req_passes_i),
        .src_valid_i(src_valid_i), .src_data_i(src_data_i), .src_ready_o(src_ready_o),
        .bc_valid_o(bc_valid_o), .bc_data_o(bc_data_o), .bc_ready_i(bc_ready_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int nchk = 0, npass = 0, nfail = 0;
    logic [63:0] q_src[$];
    logic [63:0] exp_q[$];
    logic [63:0] got[$];
    int acc_cyc[$];
    int out_cyc[$];
    int n_src, done_cnt, done_cyc, max_occ, proto_err, n_src_at11, aborted;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        nchk++;
        assert (obs === expv) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Model: producer offers len words (+extra that must never be taken);
    // output must be those len words repeated max(passes,1) times.
    task automatic prep(input int len, input int passes, input int extra, input int base);
        int np;
        q_src.delete();
        exp_q.delete();
        for (int i = 0; i < len + extra; i++)
            q_src.push_back(base >= 0 ? 64'(base + i) : {$urandom, $urandom});
        np = (passes == 0) ? 1 : passes;
        for (int p = 0; p < np; p++)
            for (int i = 0; i < len; i++) exp_q.push_back(q_src[i]);
    endtask

    task automatic run(input string tag, input int len, input int passes,
                       input int rmode, input int vmode, input int rst_after);
        int c, occ, ng;
        logic hold;
        logic [63:0] hold_d;
        got.delete(); acc_cyc.delete(); out_cyc.delete();
        n_src = 0; done_cnt = 0; done_cyc = -1; max_occ = 0; proto_err = 0;
        n_src_at11 = -1; aborted = 0; hold = 1'b0; hold_d = '0;
        @(posedge clk); #1;
        req_valid_i = 1'b1; req_len_i = 16'(len); req_passes_i = 8'(passes);
        @(negedge clk);
        chk({tag, " req_ready"}, 64'(req_ready_o), 64'd1);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        for (c = 0; c < 600; c++) begin
            src_valid_i = (q_src.size() > 0) && (vmode == 0 || $urandom_range(0, 1) == 1);
            src_data_i  = (q_src.size() > 0) ? q_src[0] : '0;
            bc_ready_i  = (rmode == 0) ? 1'b1 : (rmode == 1) ? (c >= 12) : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (hold && (!bc_valid_o || bc_data_o !== hold_d)) proto_err++;
            if (done_o && (bc_valid_o || src_ready_o || req_ready_o)) proto_err++;
            ng  = (got.size() < len) ? got.size() : len;
            occ = n_src - ng;
            if (occ > max_occ) max_occ = occ;
            if (src_valid_i && src_ready_o) begin
                void'(q_src.pop_front());
                n_src++;
                acc_cyc.push_back(c);
            end
            if (bc_valid_o && bc_ready_i) begin
                got.push_back(bc_data_o);
                out_cyc.push_back(c);
            end
            hold = bc_valid_o && !bc_ready_i;
            hold_d = bc_data_o;
            if (c == 11) n_src_at11 = n_src;
            if (done_o) begin
                done_cnt++;
                done_cyc = c;
            end
            if (rst_after > 0 && got.size() == rst_after) begin
                aborted = 1;
                rst_i = 1'b1;
                break;
            end
            @(posedge clk); #1;
            if (done_cnt > 0) break;
        end
        src_valid_i = 1'b0;
        bc_ready_i = 1'b0;
        chk({tag, " completed in budget"}, 64'(done_cnt > 0 || aborted == 1), 64'd1);
        if (aborted == 0) begin
            @(negedge clk);
            chk({tag, " req_ready after done"}, 64'(req_ready_o), 64'd1);
            chk({tag, " done_o single pulse"}, 64'(done_o), 64'd0);
        end
    endtask

    task automatic verify(input string tag, input int len);
        chk({tag, " word count"}, 64'(got.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk($sformatf("%s word %0d", tag, i), got[i], exp_q[i]);
        chk({tag, " producer handshakes"}, 64'(n_src), 64'(len));
        chk({tag, " done pulses"}, 64'(done_cnt), 64'd1);
        chk({tag, " protocol"}, 64'(proto_err), 64'd0);
        chk({tag, " occupancy bound"}, 64'(max_occ <= DEPTH), 64'd1);
        if (out_cyc.size() > 0)
            chk({tag, " done timing"}, 64'(done_cyc), 64'(out_cyc[out_cyc.size()-1] + 1));
    endtask

    initial begin
        // Reset and idle outputs
        rst_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("reset req_ready", 64'(req_ready_o), 64'd1);
        chk("reset bc_valid", 64'(bc_valid_o), 64'd0);
        chk("reset src_ready", 64'(src_ready_o), 64'd0);
        chk("reset busy", 64'(busy_o), 64'd0);
        chk("reset done", 64'(done_o), 64'd0);
        chk("reset err", 64'(err_o), 64'd0);

        // Single pass A,B,C with one-cycle latency
        prep(3, 1, 2, 'hA);
        run("single", 3, 1, 0, 0, 0);
        verify("single", 3);
        for (int i = 0; i < 3 && i < out_cyc.size() && i < acc_cyc.size(); i++)
            chk($sformatf("single latency %0d", i), 64'(out_cyc[i]), 64'(acc_cyc[i] + 1));

        // Backpressure: sink stalled for 12 cycles
        prep(20, 1, 3, -1);
        run("backpressure", 20, 1, 1, 0, 0);
        verify("backpressure", 20);
        chk("backpressure fill stops at DEPTH", 64'(n_src_at11), 64'(DEPTH));

        // Replay 1..4 three times with random sink readiness
        prep(4, 3, 2, 1);
        run("replay", 4, 3, 2, 0, 0);
        verify("replay", 4);

        // passes=0 behaves as a single pass; full-depth replay is accepted
        prep(3, 0, 1, -1);
        run("passes0", 3, 0, 2, 1, 0);
        verify("passes0", 3);
        prep(DEPTH, 2, 1, -1);
        run("fulldepth", DEPTH, 2, 2, 1, 0);
        verify("fulldepth", DEPTH);

        // Rejection: replay of a vector longer than the buffer
        @(posedge clk); #1;
        req_valid_i = 1'b1; req_len_i = 16'd9; req_passes_i = 8'd2;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        @(negedge clk);
        chk("reject err pulse", 64'(err_o), 64'd1);
        chk("reject src_ready", 64'(src_ready_o), 64'd0);
        chk("reject busy", 64'(busy_o), 64'd0);
        chk("reject req_ready", 64'(req_ready_o), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("reject err one cycle", 64'(err_o), 64'd0);

        // Zero length completes immediately
        @(posedge clk); #1;
        req_valid_i = 1'b1; req_len_i = 16'd0; req_passes_i = 8'd1;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        @(negedge clk);
        chk("zero-len done", 64'(done_o), 64'd1);
        chk("zero-len bc_valid", 64'(bc_valid_o), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("zero-len req_ready", 64'(req_ready_o), 64'd1);
        chk("zero-len done cleared", 64'(done_o), 64'd0);

        // Reset during the third pass of a replay
        prep(4, 3, 0, 1);
        run("midreset", 4, 3, 2, 0, 9);
        chk("midreset reached", 64'(aborted), 64'd1);
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("midreset bc_valid", 64'(bc_valid_o), 64'd0);
        chk("midreset busy", 64'(busy_o), 64'd0);
        chk("midreset req_ready", 64'(req_ready_o), 64'd1);
        begin
            int dseen;
            dseen = 0;
            for (int k = 0; k < 3; k++) begin
                if (done_o) dseen++;
                @(negedge clk);
            end
            chk("midreset no done", 64'(dseen), 64'd0);
        end
        prep(5, 1, 1, -1);
        run("after reset", 5, 1, 2, 1, 0);
        verify("after reset", 5);

        // Randomized requests within the replay-legal range
        for (int r = 0; r < 6; r++) begin
            int l, p;
            l = $urandom_range(1, DEPTH);
            p = $urandom_range(0, 3);
            prep(l, p, $urandom_range(0, 2), -1);
            run($sformatf("rand%0d", r), l, p, 2, 1, 0);
            verify($sformatf("rand%0d", r), l);
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

`default_nettype wire
